// File: rtl/current_monitor_pkg.sv
// Shared constants and types for the current monitor: TLI4970 code layout,
// signed current type and the magnitude helper.
package current_monitor_pkg;

  localparam int DATA_W    = 15;
  localparam int CODE_W    = 13;
  localparam int STATUS_LO = 13;
  localparam int STATUS_HI = 14;
  localparam int OFFSET    = 4096;
  localparam int CUR_W     = 16;
  localparam int AVG_LOG2  = 3;
  localparam int AVG_DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W     = CUR_W + AVG_LOG2;
  localparam int TRIP_CNT  = 4;
  localparam int TRIP_W    = 3;
  localparam int TIMEOUT   = 16000;
  localparam int STALE_W   = 14;

  typedef logic signed [CUR_W-1:0] cur_t;

  // Magnitude of a sample; offset-corrected samples never exceed 4096.
  function automatic logic [DATA_W-1:0] abs_cur(input cur_t v);
    cur_t m;
    m = v[CUR_W-1] ? -v : v;
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/current_monitor_if.sv
// Sample/limit inputs and monitor outputs between the sensor reader side
// (master) and the current monitor (slave).
interface current_monitor_if;
  import current_monitor_pkg::*;

  logic [DATA_W-1:0] cur_raw;
  logic              cur_valid;
  logic [DATA_W-1:0] oc_limit;
  logic              fault_clear;
  cur_t              cur_signed;
  cur_t              cur_avg;
  logic              avg_valid;
  logic              oc_fault;
  logic              sensor_stale;
  logic              gate_enable;
  logic [DATA_W-1:0] peak_abs;

  modport master (
    output cur_raw, cur_valid, oc_limit, fault_clear,
    input  cur_signed, cur_avg, avg_valid, oc_fault, sensor_stale, gate_enable, peak_abs
  );

  modport slave (
    input  cur_raw, cur_valid, oc_limit, fault_clear,
    output cur_signed, cur_avg, avg_valid, oc_fault, sensor_stale, gate_enable, peak_abs
  );
endinterface

// File: rtl/current_monitor_avg_buf.sv
// current_avg_buf: circular sample buffer with running sum; emits the
// moving average and its strobe one cycle after each stage-1 sample.
module current_avg_buf
  import current_monitor_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  cur_t in_data,
  output cur_t cur_avg,
  output logic avg_valid
);

  cur_t                    buf_mem [AVG_DEPTH];
  logic [AVG_LOG2-1:0]     wr_ptr;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] avg_full;

  always_comb begin
    sum_next = sum
             + $signed({{AVG_LOG2{in_data[CUR_W-1]}}, in_data})
             - $signed({{AVG_LOG2{buf_mem[wr_ptr][CUR_W-1]}}, buf_mem[wr_ptr]});
    avg_full = sum_next >>> AVG_LOG2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffer is reset because the average must ramp from zero;
      // a larger memory would normally be left unreset.
      for (int i = 0; i < AVG_DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      cur_avg   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= in_valid;
      if (in_valid) begin
        buf_mem[wr_ptr] <= in_data;
        wr_ptr          <= wr_ptr + 1'b1;
        sum             <= sum_next;
        cur_avg         <= avg_full[CUR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/current_monitor.sv
// Current monitor top: offset stage, overcurrent trip latch, stale watchdog
// and gate_enable. Optional peak tracker enabled by CURRENT_MONITOR_PEAK_EN.
module current_monitor
  import current_monitor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  current_monitor_if.slave  bus
);

  localparam cur_t                CUR_OFFSET = cur_t'(OFFSET);
  localparam logic [TRIP_W-1:0]   TRIP_V     = TRIP_W'(TRIP_CNT);
  localparam logic [STALE_W-1:0]  TIMEOUT_V  = STALE_W'(TIMEOUT);

  logic               accept;
  cur_t               s_next;
  cur_t               cur_signed;
  logic               s1_valid;
  logic               seen_first;
  logic [TRIP_W-1:0]  trip_cnt;
  logic [TRIP_W-1:0]  trip_next;
  logic               oc_fault;
  logic               oc_fault_next;
  logic               over;
  logic               clear_ok;
  logic [STALE_W-1:0] stale_cnt;
  logic               sensor_stale;
  logic               gate_enable;

  assign accept       = bus.cur_valid && (bus.cur_raw[STATUS_HI:STATUS_LO] == 2'b00);
  assign s_next       = $signed({1'b0, bus.cur_raw}) - CUR_OFFSET;
  assign sensor_stale = (stale_cnt == TIMEOUT_V);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    trip_next     = trip_cnt;
    oc_fault_next = oc_fault;
    over          = abs_cur(cur_signed) > bus.oc_limit;
    clear_ok      = bus.fault_clear && (trip_cnt == '0);
    if (s1_valid) begin
      if (over) trip_next = (trip_cnt == TRIP_V) ? trip_cnt : trip_cnt + 1'b1;
      else      trip_next = '0;
    end
    // A reached trip count dominates any concurrent clear request.
    if (trip_cnt == TRIP_V) oc_fault_next = 1'b1;
    else if (clear_ok)      oc_fault_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_signed  <= '0;
      s1_valid    <= 1'b0;
      seen_first  <= 1'b0;
      trip_cnt    <= '0;
      oc_fault    <= 1'b0;
      stale_cnt   <= '0;
      gate_enable <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s1_valid <= accept;
      if (accept) begin
        cur_signed <= s_next;
        seen_first <= 1'b1;
        stale_cnt  <= '0;
      end else if (stale_cnt != TIMEOUT_V) begin
        stale_cnt  <= stale_cnt + 1'b1;
      end
      trip_cnt    <= trip_next;
      oc_fault    <= oc_fault_next;
      gate_enable <= seen_first & ~oc_fault & ~sensor_stale;
    end
  end

  current_avg_buf u_avg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_data   (cur_signed),
    .cur_avg   (bus.cur_avg),
    .avg_valid (bus.avg_valid)
  );

`ifdef CURRENT_MONITOR_PEAK_EN
  logic [DATA_W-1:0] peak_abs;
  logic [DATA_W-1:0] s_abs;

  assign s_abs = abs_cur(s_next);

  always_ff @(posedge clk) begin
    if (reset || clear_ok)                peak_abs <= '0;
    else if (accept && (s_abs > peak_abs)) peak_abs <= s_abs;
  end

  assign bus.peak_abs = peak_abs;
`else
  assign bus.peak_abs = '0;
`endif

  assign bus.cur_signed   = cur_signed;
  assign bus.oc_fault     = oc_fault;
  assign bus.sensor_stale = sensor_stale;
  assign bus.gate_enable  = gate_enable;

endmodule
